// File: rtl/sa2_result_drain_if.sv
// Byte stream from the result drain to its consumer.
// The master side drives one beat per transfer and the slave side returns ready.
interface sa2_result_drain_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/sa2_result_drain.sv
// Captures c11..c22 on each done_sa2 rise, appends their max-pool value and streams
// the five bytes out through a 2-deep set FIFO. Define RELU_EN to clamp negative results to 0.
module sa2_result_drain #(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_sa2,
  input  logic [7:0]         c11,
  input  logic [7:0]         c12,
  input  logic [7:0]         c21,
  input  logic [7:0]         c22,
  sa2_result_drain_if.master ob,
  output logic               busy,
  output logic               overflow
);
  localparam int         NB   = 5;
  localparam logic [1:0] FULL = 2'(DEPTH);
  localparam logic [2:0] LAST = 3'(NB - 1);

  typedef struct packed {
    logic [NB-1:0][7:0] b;
  } entry_t;

  typedef enum logic {IDLE, SEND} st_t;

  st_t                st;
  logic               done_q, armed;
  logic               wp, rp;
  logic [1:0]         cnt, cnt_nxt;
  entry_t [DEPTH-1:0] mem;
  logic [3:0][7:0]    raw, val;
  logic [7:0]         mx;
  entry_t             new_e, nxt_head;
  logic               ev, full, xfer, pop, push;
  logic [2:0]         beat_nx;

  assign raw = {c22, c21, c12, c11};

  for (genvar i = 0; i < 4; i++) begin : g_lane
`ifdef RELU_EN
    assign val[i] = raw[i][7] ? 8'h00 : raw[i];
`else
    assign val[i] = raw[i];
`endif
  end

  always_comb begin
    mx = val[0];
    for (int i = 1; i < 4; i++)
      if (val[i] > mx) mx = val[i];
  end

  assign new_e = entry_t'({mx, val});

  // armed stays low until done_sa2 is seen low, so a level held across reset release is ignored
  assign ev      = done_sa2 & ~done_q & armed;
  assign full    = (cnt == FULL);
  assign xfer    = ob.out_valid & ob.out_ready;
  assign pop     = xfer & (ob.out_idx == LAST);
  assign push    = ev & (~full | pop);
  assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
  assign beat_nx = ob.out_idx + 3'd1;

  // With one set left, the follow-on head can only be the one being written this cycle
  assign nxt_head = (cnt == 2'd1) ? new_e : mem[~rp];

  assign busy = (cnt != 2'd0) | ob.out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q       <= 1'b0;
      armed        <= 1'b0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      cnt          <= 2'd0;
      mem          <= '0;
      overflow     <= 1'b0;
      st           <= IDLE;
      ob.out_valid <= 1'b0;
      ob.out_data  <= 8'h00;
      ob.out_idx   <= 3'd0;
      ob.out_last  <= 1'b0;
    end else begin
      done_q <= done_sa2;
      armed  <= armed | ~done_sa2;
      cnt    <= cnt_nxt;
      if (push) begin
        mem[wp] <= new_e;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      if (ev & full & ~pop) overflow <= 1'b1;

      if (st == IDLE) begin
        if (cnt != 2'd0) begin
          st           <= SEND;
          ob.out_valid <= 1'b1;
          ob.out_data  <= mem[rp].b[0];
          ob.out_idx   <= 3'd0;
          ob.out_last  <= 1'b0;
        end
      end else if (xfer) begin
        if (ob.out_idx != LAST) begin
          ob.out_data <= mem[rp].b[beat_nx];
          ob.out_idx  <= beat_nx;
          ob.out_last <= (beat_nx == LAST);
        end else if (cnt_nxt != 2'd0) begin
          ob.out_data <= nxt_head.b[0];
          ob.out_idx  <= 3'd0;
          ob.out_last <= 1'b0;
        end else begin
          st           <= IDLE;
          ob.out_valid <= 1'b0;
          ob.out_data  <= 8'h00;
          ob.out_idx   <= 3'd0;
          ob.out_last  <= 1'b0;
        end
      end
    end
  end
endmodule
